// File: rtl/capture_sequencer.sv
// Capture sequencer: circular pre/post-trigger sample capture into RAM,
// then a chronological byte dump of the RAM to a UART transmitter.
module capture_sequencer #(
   parameter int ENTRIES = 384,
   parameter int AW      = 9
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          run,
   input  logic          trig,
   input  logic          smpl_en,
   input  logic [AW-1:0] trig_pos,
   input  logic          dump_req,
   input  logic [7:0]    rdata,
   input  logic          tx_rdy,
   output logic          we,
   output logic [AW-1:0] waddr,
   output logic [AW-1:0] raddr,
   output logic          armed,
   output logic          capture_done,
   output logic          clr_run,
   output logic [7:0]    tx_data,
   output logic          tx_vld,
   output logic          dump_done
);

   localparam int CW = AW + 1;
   localparam logic [AW-1:0] LAST = AW'(ENTRIES - 1);
   localparam logic [CW-1:0] ENT  = CW'(ENTRIES);

   typedef enum logic [2:0] {
      IDLE, PRE, WAIT_TRIG, POST, DONE, DUMP_RD, DUMP_TX
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] waddr_q, waddr_d;
   logic [AW-1:0] raddr_q, raddr_d;
   logic [AW-1:0] tp_q, tp_d;
   logic [CW-1:0] pre_cnt_q, pre_cnt_d;
   logic [CW-1:0] post_cnt_q, post_cnt_d;
   logic [CW-1:0] byte_cnt_q, byte_cnt_d;
   logic          armed_q, armed_d;
   logic          done_q, done_d;
   logic [7:0]    tx_data_q, tx_data_d;
   logic          tx_vld_q, tx_vld_d;
   logic          dump_done_q, dump_done_d;
   logic          rd_wait_q, rd_wait_d;

   logic          capturing, wr;
   logic          go_start, go_done, go_abort;
   logic [AW-1:0] tp_in, waddr_inc, raddr_inc;
   logic [CW-1:0] pre_inc, post_inc, byte_inc;

   assign tp_in     = (trig_pos > LAST) ? LAST : trig_pos;
   assign waddr_inc = (waddr_q == LAST) ? '0 : waddr_q + 1'b1;
   assign raddr_inc = (raddr_q == LAST) ? '0 : raddr_q + 1'b1;
   assign pre_inc   = pre_cnt_q + 1'b1;
   assign post_inc  = post_cnt_q + 1'b1;
   assign byte_inc  = byte_cnt_q + 1'b1;

   assign capturing = (state_q == PRE) || (state_q == WAIT_TRIG) ||
                      (state_q == POST);
   // A cycle that drops run aborts, so its sample is not stored
   assign wr        = capturing && run && smpl_en;

   always_comb begin
      state_d     = state_q;
      waddr_d     = waddr_q;
      raddr_d     = raddr_q;
      tp_d        = tp_q;
      pre_cnt_d   = pre_cnt_q;
      post_cnt_d  = post_cnt_q;
      byte_cnt_d  = byte_cnt_q;
      armed_d     = armed_q;
      done_d      = done_q;
      tx_data_d   = tx_data_q;
      tx_vld_d    = tx_vld_q;
      dump_done_d = 1'b0;
      rd_wait_d   = rd_wait_q;
      clr_run     = 1'b0;
      go_start    = 1'b0;
      go_done     = 1'b0;
      go_abort    = capturing && !run;

      if (wr) waddr_d = waddr_inc;

      unique case (state_q)
         IDLE: go_start = run;
         PRE: begin
            if (wr) begin
               pre_cnt_d = pre_inc;
               if (pre_inc == ENT - {1'b0, tp_q}) begin
                  armed_d = 1'b1;
                  state_d = WAIT_TRIG;
               end
            end
         end
         WAIT_TRIG: begin
            if (trig) begin
               post_cnt_d = '0;
               if (tp_q == '0) go_done = 1'b1;
               else state_d = POST;
            end
         end
         POST: begin
            if (wr) begin
               post_cnt_d = post_inc;
               go_done    = (post_inc == {1'b0, tp_q});
            end
         end
         DONE: begin
            if (dump_req) begin
               state_d    = DUMP_RD;
               raddr_d    = waddr_q;
               byte_cnt_d = '0;
               rd_wait_d  = 1'b0;
            end else begin
               go_start = run;
            end
         end
         DUMP_RD: begin
            if (!rd_wait_q) begin
               rd_wait_d = 1'b1;
            end else begin
               rd_wait_d = 1'b0;
               tx_data_d = rdata;
               tx_vld_d  = 1'b1;
               state_d   = DUMP_TX;
            end
         end
         DUMP_TX: begin
            if (tx_rdy) begin
               raddr_d    = raddr_inc;
               byte_cnt_d = byte_inc;
               tx_vld_d   = 1'b0;
               if (byte_inc == ENT) begin
                  dump_done_d = 1'b1;
                  state_d     = DONE;
               end else begin
                  state_d = DUMP_RD;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (go_start) begin
         state_d   = PRE;
         done_d    = 1'b0;
         armed_d   = 1'b0;
         pre_cnt_d = '0;
         waddr_d   = '0;
         tp_d      = tp_in;
      end
      if (go_done && !go_abort) begin
         state_d = DONE;
         done_d  = 1'b1;
         armed_d = 1'b0;
         clr_run = 1'b1;
      end
      if (go_abort) begin
         state_d = IDLE;
         armed_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         waddr_q     <= '0;
         raddr_q     <= '0;
         tp_q        <= '0;
         pre_cnt_q   <= '0;
         post_cnt_q  <= '0;
         byte_cnt_q  <= '0;
         armed_q     <= 1'b0;
         done_q      <= 1'b0;
         tx_data_q   <= '0;
         tx_vld_q    <= 1'b0;
         dump_done_q <= 1'b0;
         rd_wait_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         waddr_q     <= waddr_d;
         raddr_q     <= raddr_d;
         tp_q        <= tp_d;
         pre_cnt_q   <= pre_cnt_d;
         post_cnt_q  <= post_cnt_d;
         byte_cnt_q  <= byte_cnt_d;
         armed_q     <= armed_d;
         done_q      <= done_d;
         tx_data_q   <= tx_data_d;
         tx_vld_q    <= tx_vld_d;
         dump_done_q <= dump_done_d;
         rd_wait_q   <= rd_wait_d;
      end
   end

   assign we           = wr;
   assign waddr        = waddr_q;
   assign raddr        = raddr_q;
   assign armed        = armed_q;
   assign capture_done = done_q;
   assign tx_data      = tx_data_q;
   assign tx_vld       = tx_vld_q;
   assign dump_done    = dump_done_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// Bench for capture_sequencer: RAM model, run-bit register model and a
// scoreboard queue of expected dump bytes.
module tb_capture_sequencer;

   logic       clk = 1'b0;
   logic       rst, run, trig, smpl_en, dump_req, tx_rdy;
   logic [8:0] trig_pos;
   logic [7:0] rdata, wdata;
   logic       we, armed, capture_done, clr_run, tx_vld, dump_done;
   logic [8:0] waddr, raddr;
   logic [7:0] tx_data;

   logic [7:0]  mem [0:511];
   logic [31:0] smp;
   logic [7:0]  sbq [$];
   int nvec, nbad, nwr, nclr, ndd, ntx, w0, c0;
   logic clr_pend;

   always #5 clk = ~clk;

   capture_sequencer dut (
      .clk(clk), .rst(rst), .run(run), .trig(trig), .smpl_en(smpl_en),
      .trig_pos(trig_pos), .dump_req(dump_req), .rdata(rdata),
      .tx_rdy(tx_rdy), .we(we), .waddr(waddr), .raddr(raddr),
      .armed(armed), .capture_done(capture_done), .clr_run(clr_run),
      .tx_data(tx_data), .tx_vld(tx_vld), .dump_done(dump_done)
   );

   assign wdata = smp[7:0];

   always @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nbad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock: observe at negedge+1, then advance to the next negedge.
   task automatic cyc();
      #1;
      if (we) nwr++;
      if (clr_run) begin
         nclr++;
         clr_pend = 1'b1;
      end
      if (dump_done) ndd++;
      if (tx_vld && tx_rdy) begin
         if (ntx == 367) chk("trig_byte", 32'(tx_data), 32'(8'd143));
         if (sbq.size() == 0) chk("sb_underflow", 32'(ntx), 32'd384);
         else chk("dump_byte", 32'(tx_data), 32'(sbq.pop_front()));
         ntx++;
      end
      @(negedge clk);
      trig     = 1'b0;
      dump_req = 1'b0;
      if (smpl_en) smp++;
      if (clr_pend) begin
         run      = 1'b0;
         clr_pend = 1'b0;
      end
   endtask

   task automatic start_capture(input int tpi);
      trig_pos = 9'(tpi);
      smpl_en  = 1'b0;
      run      = 1'b1;
      cyc();
      smp     = 0;
      smpl_en = 1'b1;
   endtask

   task automatic capture(input int tpi, input int ntrig);
      start_capture(tpi);
      repeat (ntrig - 1) cyc();
      trig = 1'b1;
      cyc();
      repeat (tpi) cyc();
   endtask

   task automatic dump(input int nw, input int div, input int stop_at);
      sbq.delete();
      for (int i = 0; i < 384; i++) sbq.push_back(8'(nw - 384 + i));
      ntx      = 0;
      ndd      = 0;
      dump_req = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         if (stop_at > 0 && ntx == stop_at) break;
         if (ndd != 0) break;
         if (c == 10) chk("done_in_dump", 32'(capture_done), 32'd1);
         tx_rdy = ((c % div) == 0);
         cyc();
      end
      tx_rdy = 1'b0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_we"}, 32'(we), 0);
      chk({tag, "_waddr"}, 32'(waddr), 0);
      chk({tag, "_raddr"}, 32'(raddr), 0);
      chk({tag, "_armed"}, 32'(armed), 0);
      chk({tag, "_cdone"}, 32'(capture_done), 0);
      chk({tag, "_clr"}, 32'(clr_run), 0);
      chk({tag, "_txd"}, 32'(tx_data), 0);
      chk({tag, "_txv"}, 32'(tx_vld), 0);
      chk({tag, "_ddone"}, 32'(dump_done), 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      nvec = 0; nbad = 0; nwr = 0; nclr = 0; ndd = 0; ntx = 0;
      clr_pend = 1'b0; smp = 0;
      rst = 1'b1; run = 1'b0; trig = 1'b0; smpl_en = 1'b0;
      dump_req = 1'b0; tx_rdy = 1'b0; trig_pos = '0;
      @(negedge clk);
      cyc();
      cyc();
      chk_zero("reset");
      rst = 1'b0;
      cyc();

      // Normal capture, trigger on sample 400, tp=16
      start_capture(16);
      nwr = 0; nclr = 0;
      repeat (367) cyc();
      chk("armed_367", 32'(armed), 0);
      cyc();
      chk("armed_368", 32'(armed), 1);
      repeat (31) cyc();
      trig = 1'b1;
      cyc();
      chk("post_nodone", 32'(capture_done), 0);
      repeat (15) cyc();
      chk("done_15", 32'(capture_done), 0);
      cyc();
      chk("done_16", 32'(capture_done), 1);
      chk("armed_off", 32'(armed), 0);
      chk("writes", 32'(nwr), 416);
      chk("clr_pulses", 32'(nclr), 1);
      chk("waddr_end", 32'(waddr), 32);
      repeat (8) cyc();
      chk("we_quiet", 32'(nwr), 416);
      chk("run_cleared", 32'(run), 0);

      // Dump with tx_rdy 1-of-3, run raised together with dump_req
      run = 1'b1;
      dump(416, 3, 0);
      chk("dump_bytes", 32'(ntx), 384);
      chk("dump_done_n", 32'(ndd), 1);
      chk("sb_left", 32'(sbq.size()), 0);
      chk("txv_after", 32'(tx_vld), 0);
      chk("restart", 32'(capture_done), 0);
      run = 1'b0;
      cyc();
      cyc();

      // Early trigger ignored, later trigger accepted
      start_capture(16);
      c0 = nclr;
      repeat (99) cyc();
      trig = 1'b1;
      cyc();
      chk("early_armed", 32'(armed), 0);
      repeat (268) cyc();
      chk("late_armed", 32'(armed), 1);
      repeat (5) cyc();
      trig = 1'b1;
      cyc();
      repeat (15) cyc();
      chk("late_done15", 32'(capture_done), 0);
      cyc();
      chk("late_done16", 32'(capture_done), 1);
      chk("late_clr", 32'(nclr - c0), 1);

      // tp=0: done on the trigger cycle, no post writes
      start_capture(0);
      chk("tp0_cleared", 32'(capture_done), 0);
      repeat (383) cyc();
      chk("tp0_arm383", 32'(armed), 0);
      cyc();
      chk("tp0_arm384", 32'(armed), 1);
      repeat (3) cyc();
      w0 = nwr;
      trig = 1'b1;
      cyc();
      chk("tp0_done", 32'(capture_done), 1);
      repeat (3) cyc();
      chk("tp0_writes", 32'(nwr - w0), 1);

      // trig_pos above range clamps to 383
      start_capture(500);
      cyc();
      chk("tp500_arm", 32'(armed), 1);
      trig = 1'b1;
      cyc();
      repeat (382) cyc();
      chk("tp500_382", 32'(capture_done), 0);
      cyc();
      chk("tp500_383", 32'(capture_done), 1);

      // Abort during POST
      start_capture(16);
      repeat (368) cyc();
      trig = 1'b1;
      cyc();
      repeat (5) cyc();
      c0 = nclr;
      run = 1'b0;
      cyc();
      chk("abort_cdone", 32'(capture_done), 0);
      chk("abort_armed", 32'(armed), 0);
      chk("abort_noclr", 32'(nclr - c0), 0);
      w0 = nwr;
      dump_req = 1'b1;
      tx_rdy = 1'b1;
      cyc();
      repeat (6) cyc();
      tx_rdy = 1'b0;
      chk("abort_nodump", 32'(tx_vld), 0);
      chk("abort_nowe", 32'(nwr - w0), 0);

      // Reset mid-dump, then a clean capture and dump
      capture(16, 400);
      chk("rcap_done", 32'(capture_done), 1);
      dump(416, 1, 50);
      chk("rdump_50", 32'(ntx), 50);
      rst = 1'b1;
      smpl_en = 1'b0;
      cyc();
      chk_zero("midrst");
      rst = 1'b0;
      sbq.delete();
      cyc();
      w0 = nwr;
      capture(16, 400);
      chk("rcap2_done", 32'(capture_done), 1);
      chk("rcap2_writes", 32'(nwr - w0), 416);
      dump(416, 3, 0);
      chk("rdump2_bytes", 32'(ntx), 384);
      chk("rdump2_ddone", 32'(ndd), 1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule

// File: doc/capture_sequencer.md
CAPTURE_SEQUENCER -- requirements
Module: capture_sequencer

Interface
REQ-001 Parameter ENTRIES, default 384, sample RAM depth in samples.
REQ-002 Parameter AW, default 9, RAM address width; ENTRIES SHALL be <= 2^AW.
REQ-003 clk  in  1  sole clock; all logic SHALL be on posedge clk.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 run  in  1  level run bit from the TrigCfg register.
REQ-006 trig  in  1  one-cycle trigger pulse from the trigger logic.
REQ-007 smpl_en  in  1  decimated sample strobe, one cycle per stored sample.
REQ-008 trig_pos  in  AW  number of samples to store after the trigger.
REQ-009 dump_req  in  1  one-cycle pulse requesting a dump of the RAM.
REQ-010 rdata  in  8  RAM read data, valid 1 cycle after raddr.
REQ-011 tx_rdy  in  1  UART transmitter can accept a byte.
REQ-012 we  out  1  RAM write enable.
REQ-013 waddr  out  AW  RAM write address.
REQ-014 raddr  out  AW  RAM read address.
REQ-015 armed  out  1  enough pre-trigger samples stored; trig is now accepted.
REQ-016 capture_done  out  1  capture complete; mirrors the TrigCfg capture_done bit.
REQ-017 clr_run  out  1  one-cycle pulse that clears the run bit.
REQ-018 tx_data  out  8  byte to the UART.
REQ-019 tx_vld  out  1  tx_data valid.
REQ-020 dump_done  out  1  one-cycle pulse after the last dump byte is accepted.

Function
REQ-021 States SHALL be IDLE, PRE, WAIT_TRIG, POST, DONE, DUMP_RD and DUMP_TX.
REQ-022 Effective position SHALL be tp = min(trig_pos, ENTRIES-1), sampled on entry to PRE and held until IDLE.
REQ-023 IDLE: when run=1, go to PRE and clear capture_done, pre_cnt and waddr.
REQ-024 PRE/WAIT_TRIG/POST: when smpl_en=1, drive we=1 in that cycle and advance waddr after the write; at ENTRIES-1, waddr wraps to 0.
REQ-025 PRE: pre_cnt increments per write; at pre_cnt = ENTRIES-tp, set armed=1 and go to WAIT_TRIG.
REQ-026 trig in PRE (armed=0) SHALL be ignored.
REQ-027 WAIT_TRIG: trig=1 goes to POST with post_cnt=0; a sample written in the trigger cycle counts as pre-trigger.
REQ-028 POST: post_cnt increments per write; at post_cnt = tp, go to DONE.
REQ-029 tp=0: trig SHALL go straight to DONE with no post-trigger write.
REQ-030 Entry to DONE: capture_done=1, clr_run pulses 1 cycle, armed=0, and we SHALL stay 0 until the next capture.
REQ-031 run=0 in PRE, WAIT_TRIG or POST: abort to IDLE next cycle; capture_done stays 0, armed=0, and clr_run is not pulsed.
REQ-032 DONE with dump_req=1: set raddr=waddr (oldest sample) and go to DUMP_RD.
REQ-033 dump_req in any state other than DONE SHALL be ignored.
REQ-034 DUMP_RD: wait 1 cycle for rdata, then latch rdata into tx_data, assert tx_vld and go to DUMP_TX.
REQ-035 DUMP_TX: hold tx_vld and tx_data until tx_rdy=1; on transfer, increment raddr (wrapping at ENTRIES-1) and byte count.
REQ-036 After the ENTRIES-th transfer: pulse dump_done, drop tx_vld and return to DONE; otherwise go to DUMP_RD.
REQ-037 DONE with run=1 and no dump_req SHALL start a new capture exactly as from IDLE.
REQ-038 Simultaneous run=1 and dump_req in DONE: the dump SHALL win, and run is honored only after the dump returns to DONE.
REQ-039 Exactly ENTRIES bytes SHALL be sent per dump, in chronological order, with the trigger sample at byte index ENTRIES-tp-1.

Reset
REQ-040 rst=1 SHALL force IDLE at the next edge from any state, including mid-dump.
REQ-041 On rst, all outputs SHALL go to 0: we, waddr, raddr, armed, capture_done, clr_run, tx_data, tx_vld and dump_done.
REQ-042 On rst, pre_cnt, post_cnt, byte count and tp SHALL be cleared.

Verification
REQ-043 Normal capture: trig_pos=16, smpl_en every cycle, run=1, trig at sample 400 -> armed at write 368; capture_done after 16 post writes; one clr_run pulse; we=0 afterwards.
REQ-044 Early trigger: trig pulse at write 100 with trig_pos=16 -> ignored, armed=0; a later trig after armed is accepted.
REQ-045 Boundaries: trig_pos=0 -> done on the trig cycle with 0 post writes; trig_pos=500 -> behaves as tp=383 (armed after 1 write).
REQ-046 Dump: after the REQ-043 capture, dump_req with tx_rdy toggling 1-of-3 cycles -> 384 bytes starting at waddr with wrap; trigger byte at index 367; one dump_done.
REQ-047 Abort: run dropped during POST -> IDLE, capture_done=0, no clr_run; a following dump_req is ignored.
REQ-048 Reset: rst asserted at dump byte 50 -> all outputs 0 at the next edge, and a new capture runs cleanly.
